conv_acc_9: RTL and testbench

- Pipelined, parametrised 3x3 convolution accumulator for the NN datapath.
- Each input beat carries one 3x3 window and its 3x3 kernel for one input channel. The block accumulates NCH beats per output pixel and adds a bias.
- After accumulation it rescales by FRAC, optionally applies ReLU and saturates to DAT_W.
- Valid/ready on both sides. Feeds the max-pool/activation stage downstream.

---
 rtl/conv_acc_9_pkg.sv | 23 ++
 rtl/conv_acc_9_if.sv | 39 +++
 rtl/conv_acc_9_dot_prod_9.sv | 37 +++
 rtl/conv_acc_9.sv | 118 +++++++++++
 tb/tb_conv_acc_9.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_acc_9_pkg.sv
// conv_acc_9_pkg: shared defaults and helpers for the 3x3 convolution accumulator.
//   DAT_W_DEF  activation width (signed)
//   PAR_W_DEF  weight/bias width (signed)
//   FRAC_DEF   fractional bits of data and weights
//   NCH_DEF    input-channel beats per output pixel
//   GUARD_DEF  accumulator headroom bits
package conv_acc_9_pkg;

   localparam int unsigned DAT_W_DEF = 22;
   localparam int unsigned PAR_W_DEF = 16;
   localparam int unsigned FRAC_DEF  = 14;
   localparam int unsigned NCH_DEF   = 3;
   localparam int unsigned GUARD_DEF = 6;

   // Taps in one 3x3 window.
   localparam int unsigned N_TAPS = 9;

   // Counter width able to hold 0..n-1; at least one bit so NCH=1 still elaborates.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/conv_acc_9_if.sv
// conv_acc_9_if: valid/ready beat input and result output of conv_acc_9.
//   in_valid/in_ready  beat handshake
//   in_data            9 activations, element k at [k*DAT_W +: DAT_W]
//   in_wgt             9 weights, element k at [k*PAR_W +: PAR_W]
//   in_bias            bias in Q.FRAC, used on the first beat of a group
//   relu_en            ReLU mode, used on the last beat of a group
//   out_valid/out_ready result handshake
//   out_data/out_sat   result and clip flag
interface conv_acc_9_if
   import conv_acc_9_pkg::*;
#(
   parameter int unsigned DAT_W = DAT_W_DEF,
   parameter int unsigned PAR_W = PAR_W_DEF
);

   logic                       in_valid;
   logic                       in_ready;
   logic [N_TAPS*DAT_W-1:0]    in_data;
   logic [N_TAPS*PAR_W-1:0]    in_wgt;
   logic signed [PAR_W-1:0]    in_bias;
   logic                       relu_en;
   logic                       out_valid;
   logic                       out_ready;
   logic signed [DAT_W-1:0]    out_data;
   logic                       out_sat;

   // Upstream producer / downstream consumer side.
   modport master (
      output in_valid, in_data, in_wgt, in_bias, relu_en, out_ready,
      input  in_ready, out_valid, out_data, out_sat
   );

   // Accumulator side.
   modport slave (
      input  in_valid, in_data, in_wgt, in_bias, relu_en, out_ready,
      output in_ready, out_valid, out_data, out_sat
   );

endinterface

// File: rtl/conv_acc_9_dot_prod_9.sv
// dot_prod_9: combinational 9-term signed multiply-add at full precision.
//   data   9 signed activations, DAT_W each
//   wgt    9 signed weights, PAR_W each
//   sum_c  signed sum of products, DAT_W+PAR_W+4 bits (never overflows)
module dot_prod_9
   import conv_acc_9_pkg::*;
#(
   parameter int unsigned DAT_W = DAT_W_DEF,
   parameter int unsigned PAR_W = PAR_W_DEF
) (
   input  logic [N_TAPS*DAT_W-1:0]            data,
   input  logic [N_TAPS*PAR_W-1:0]            wgt,
   output logic signed [DAT_W+PAR_W+4-1:0]    sum_c
);

   localparam int unsigned MUL_W = DAT_W + PAR_W;
   localparam int unsigned SUM_W = MUL_W + 4;

   logic signed [DAT_W-1:0] d;
   logic signed [PAR_W-1:0] w;
   logic signed [MUL_W-1:0] p;

   // Four extra bits cover the growth of nine full-scale products.
   always_comb begin
      sum_c = '0;
      d     = '0;
      w     = '0;
      p     = '0;
      for (int k = 0; k < int'(N_TAPS); k++) begin
         d     = $signed(data[k*DAT_W +: DAT_W]);
         w     = $signed(wgt[k*PAR_W +: PAR_W]);
         p     = MUL_W'(d) * MUL_W'(w);
         sum_c = sum_c + SUM_W'(p);
      end
   end

endmodule

// File: rtl/conv_acc_9.sv
// conv_acc_9: pipelined 3x3 convolution accumulator.
// Accumulates NCH window/kernel beats per output pixel on top of a bias,
// rescales by FRAC (floor), optionally applies ReLU and saturates to DAT_W.
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    conv_acc_9_if.slave (beat in, result out, valid/ready on both)
module conv_acc_9
   import conv_acc_9_pkg::*;
#(
   parameter int unsigned DAT_W = DAT_W_DEF,
   parameter int unsigned PAR_W = PAR_W_DEF,
   parameter int unsigned FRAC  = FRAC_DEF,
   parameter int unsigned NCH   = NCH_DEF,
   parameter int unsigned GUARD = GUARD_DEF
) (
   input logic         clk,
   input logic         rst_n,
   conv_acc_9_if.slave bus
);

   localparam int unsigned PROD_W = DAT_W + PAR_W + 4;
   localparam int unsigned ACC_W  = DAT_W + PAR_W + GUARD;
   localparam int unsigned R_W    = ACC_W - FRAC;
   localparam int unsigned CNT_W  = cnt_width(NCH);

   logic                     en_c;
   logic signed [PROD_W-1:0] dp_sum_c;

   logic [CNT_W-1:0]         cnt;
   logic                     s1_valid;
   logic signed [PROD_W-1:0] s1_sum;
   logic                     s1_first;
   logic                     s1_last;
   logic signed [ACC_W-1:0]  s1_bias;
   logic                     s1_relu;
   logic signed [ACC_W-1:0]  acc;

   logic                     out_valid_q;
   logic signed [DAT_W-1:0]  out_data_q;
   logic                     out_sat_q;

   logic signed [ACC_W-1:0]  acc_next_c;
   logic signed [R_W-1:0]    r_c;
   logic [R_W-DAT_W:0]       hi_c;
   logic signed [DAT_W-1:0]  sat_data_c;
   logic                     sat_flag_c;

   // Whole pipeline advances together; a held result freezes everything.
   assign en_c          = !out_valid_q || bus.out_ready;
   assign bus.in_ready  = en_c;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sat   = out_sat_q;

   dot_prod_9 #(
      .DAT_W (DAT_W),
      .PAR_W (PAR_W)
   ) u_dot (
      .data  (bus.in_data),
      .wgt   (bus.in_wgt),
      .sum_c (dp_sum_c)
   );

   // Accumulate, rescale (arithmetic shift = floor), ReLU, clip to DAT_W.
   always_comb begin
      acc_next_c = (s1_first ? s1_bias : acc) + ACC_W'(s1_sum);
      r_c        = R_W'(acc_next_c >>> FRAC);
      if (s1_relu && r_c[R_W-1]) begin
         r_c = '0;
      end
      // Value fits when all bits from the DAT_W sign bit upward agree.
      hi_c       = r_c[R_W-1:DAT_W-1];
      sat_flag_c = !((&hi_c) || !(|hi_c));
      if (!sat_flag_c) begin
         sat_data_c = r_c[DAT_W-1:0];
      end else if (r_c[R_W-1]) begin
         sat_data_c = {1'b1, {(DAT_W-1){1'b0}}};
      end else begin
         sat_data_c = {1'b0, {(DAT_W-1){1'b1}}};
      end
   end

   // Stage 1 capture, group counter, accumulator and output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         s1_valid    <= 1'b0;
         s1_sum      <= '0;
         s1_first    <= 1'b0;
         s1_last     <= 1'b0;
         s1_bias     <= '0;
         s1_relu     <= 1'b0;
         acc         <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
      end else if (en_c) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_sum   <= dp_sum_c;
            s1_first <= (cnt == '0);
            s1_last  <= (cnt == CNT_W'(NCH - 1));
            s1_bias  <= ACC_W'(bus.in_bias) <<< FRAC;
            s1_relu  <= bus.relu_en;
            cnt      <= (cnt == CNT_W'(NCH - 1)) ? '0 : cnt + CNT_W'(1);
         end
         if (s1_valid) begin
            acc <= acc_next_c;
         end
         out_valid_q <= s1_valid && s1_last;
         if (s1_valid && s1_last) begin
            out_data_q <= sat_data_c;
            out_sat_q  <= sat_flag_c;
         end
      end
   end

endmodule

// File: tb/tb_conv_acc_9.sv
// tb_conv_acc_9: scoreboard bench for conv_acc_9 with one NCH=1 and one NCH=3 instance.
// Directed beats push hand-computed results into per-instance queues; a monitor
// pops and compares on every accepted output.
module tb_conv_acc_9;
   import conv_acc_9_pkg::*;

   localparam int unsigned DW = 22;
   localparam int unsigned PW = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   conv_acc_9_if #(.DAT_W(DW), .PAR_W(PW)) if1 ();
   conv_acc_9_if #(.DAT_W(DW), .PAR_W(PW)) if3 ();

   conv_acc_9 #(.DAT_W(DW), .PAR_W(PW), .FRAC(14), .NCH(1), .GUARD(6)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if1)
   );

   conv_acc_9 #(.DAT_W(DW), .PAR_W(PW), .FRAC(14), .NCH(3), .GUARD(6)) u_dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if3)
   );

   typedef struct {
      string  name;
      longint d;
      longint s;
   } exp_t;

   exp_t q1[$];
   exp_t q3[$];
   int   checks = 0;
   int   errors = 0;

   logic signed [DW-1:0] held_d;
   logic                 held_s;

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [9*DW-1:0] vec_d(input longint v, input bit all);
      logic [9*DW-1:0] r;
      r = '0;
      for (int k = 0; k < 9; k++) if (all || k == 0) r[k*DW +: DW] = DW'(v);
      return r;
   endfunction

   function automatic logic [9*PW-1:0] vec_w(input longint v, input bit all);
      logic [9*PW-1:0] r;
      r = '0;
      for (int k = 0; k < 9; k++) if (all || k == 0) r[k*PW +: PW] = PW'(v);
      return r;
   endfunction

   task automatic exp1(input string name, input longint d, input longint s);
      q1.push_back('{name, d, s});
   endtask

   task automatic exp3(input string name, input longint d, input longint s);
      q3.push_back('{name, d, s});
   endtask

   // One beat on the NCH=1 instance; valid drops right after acceptance.
   task automatic beat1(input longint d, input longint w, input bit all, input longint b, input bit relu);
      int n;
      n = 0;
      @(negedge clk);
      if1.in_valid = 1'b1;
      if1.in_data  = vec_d(d, all);
      if1.in_wgt   = vec_w(w, all);
      if1.in_bias  = PW'(b);
      if1.relu_en  = relu;
      while (!if1.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("dut1_in_ready_wait", 64'(if1.in_ready), 1);
      @(posedge clk);
      #1 if1.in_valid = 1'b0;
   endtask

   // One beat on the NCH=3 instance, tap 0 only.
   task automatic beat3(input longint d, input longint w, input longint b, input bit relu);
      int n;
      n = 0;
      @(negedge clk);
      if3.in_valid = 1'b1;
      if3.in_data  = vec_d(d, 1'b0);
      if3.in_wgt   = vec_w(w, 1'b0);
      if3.in_bias  = PW'(b);
      if3.relu_en  = relu;
      while (!if3.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("dut3_in_ready_wait", 64'(if3.in_ready), 1);
      @(posedge clk);
      #1 if3.in_valid = 1'b0;
   endtask

   // Weight 1.0 on tap 0, so each beat contributes x; bias on later beats must be ignored.
   task automatic grp3(input string name, input longint x0, input longint x1, input longint x2,
                       input longint b, input longint ed, input longint es);
      exp3(name, ed, es);
      beat3(x0, 16384, b, 1'b0);
      beat3(x1, 16384, 999, 1'b0);
      beat3(x2, 16384, -999, 1'b0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q1.size() != 0 || q3.size() != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("drain_q1", 64'(q1.size()), 0);
      chk("drain_q3", 64'(q3.size()), 0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      if1.in_valid = 1'b0; if1.in_data = '0; if1.in_wgt = '0; if1.in_bias = '0;
      if1.relu_en = 1'b0;  if1.out_ready = 1'b1;
      if3.in_valid = 1'b0; if3.in_data = '0; if3.in_wgt = '0; if3.in_bias = '0;
      if3.relu_en = 1'b0;  if3.out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #2;
      chk("rst_out_valid1", 64'(if1.out_valid), 0);
      chk("rst_out_data1",  64'(if1.out_data), 0);
      chk("rst_out_sat3",   64'(if3.out_sat), 0);
      chk("rst_out_valid3", 64'(if3.out_valid), 0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      chk("in_ready1_after_rst", 64'(if1.in_ready), 1);
      chk("in_ready3_after_rst", 64'(if3.in_ready), 1);

      fork
         forever begin : mon
            exp_t e;
            @(negedge clk);
            if (rst_n && if1.out_valid && if1.out_ready) begin
               if (q1.size() == 0) chk("dut1_unexpected_output", 1, 0);
               else begin
                  e = q1.pop_front();
                  chk({e.name, "_data"}, 64'(if1.out_data), e.d);
                  chk({e.name, "_sat"},  64'(if1.out_sat),  e.s);
               end
            end
            if (rst_n && if3.out_valid && if3.out_ready) begin
               if (q3.size() == 0) chk("dut3_unexpected_output", 1, 0);
               else begin
                  e = q3.pop_front();
                  chk({e.name, "_data"}, 64'(if3.out_data), e.d);
                  chk({e.name, "_sat"},  64'(if3.out_sat),  e.s);
               end
            end
         end
      join_none

      // NCH=1: 9 * 1.0 * 1.0 = 9.0, plus two-register latency.
      exp1("unit_all", 147456, 0);
      beat1(16384, 16384, 1'b1, 0, 1'b0);
      @(negedge clk) chk("lat_stage1", 64'(if1.out_valid), 0);
      @(negedge clk) chk("lat_out",    64'(if1.out_valid), 1);

      exp1("floor_neg1", -1, 0);         beat1(1, -1, 1'b0, 0, 1'b0);
      exp1("max_exact", 2097151, 0);     beat1(2097151, 16384, 1'b0, 0, 1'b0);
      exp1("min_exact", -2097152, 0);    beat1(-2097152, 16384, 1'b0, 0, 1'b0);
      exp1("sat_pos", 2097151, 1);       beat1(2097151, 32767, 1'b1, 0, 1'b0);
      exp1("sat_neg", -2097152, 1);      beat1(2097151, -32768, 1'b1, 0, 1'b0);
      exp1("bias_only", -32768, 0);      beat1(0, 0, 1'b1, -32768, 1'b0);
      exp1("relu_nch1", 0, 0);           beat1(1, -1, 1'b0, 0, 1'b1);

      // NCH=3: 3 * (1.0 * 0.5) + 1.0 = 2.5.
      exp3("frac_2p5", 40960, 0);
      beat3(16384, 8192, 16384, 1'b0);
      beat3(16384, 8192, 0, 1'b0);
      beat3(16384, 8192, 0, 1'b0);

      exp3("relu_on", 0, 0);
      beat3(16384, -16384, 0, 1'b1); beat3(0, 0, 0, 1'b1); beat3(0, 0, 0, 1'b1);
      exp3("relu_off", -16384, 0);
      beat3(16384, -16384, 0, 1'b0); beat3(0, 0, 0, 1'b0); beat3(0, 0, 0, 1'b0);
      exp3("relu_last_only", 0, 0);
      beat3(16384, -16384, 0, 1'b0); beat3(0, 0, 0, 1'b0); beat3(0, 0, 0, 1'b1);
      exp3("relu_first_only", -16384, 0);
      beat3(16384, -16384, 0, 1'b1); beat3(0, 0, 0, 1'b0); beat3(0, 0, 0, 1'b0);

      grp3("bias_first", 100, 200, 300, 50, 650, 0);
      grp3("acc_sat", 2000000, 2000000, 2000000, 0, 2097151, 1);
      grp3("acc_cancel", 2000000, 2000000, -2000000, 0, 2000000, 0);
      drain();

      // Backpressure: hold the first result for 5 cycles while beats keep coming.
      fork
         begin
            grp3("bp_a", 1000, 2000, 3000, 5, 6005, 0);
            grp3("bp_b", -7, -8, -9, 0, -24, 0);
            grp3("bp_c", 12345, 1, 1, -1, 12346, 0);
            grp3("bp_d", 40000, 50000, 60000, 100, 150100, 0);
         end
         begin
            int n;
            n = 0;
            do begin
               @(posedge clk);
               #1;
               n++;
            end while (!if3.out_valid && n < 200);
            chk("bp_out_valid_seen", 64'(if3.out_valid), 1);
            if3.out_ready = 1'b0;
            held_d = if3.out_data;
            held_s = if3.out_sat;
            repeat (5) begin
               @(negedge clk);
               chk("bp_in_ready_low",  64'(if3.in_ready), 0);
               chk("bp_out_valid_hold", 64'(if3.out_valid), 1);
               chk("bp_out_data_stable", 64'(if3.out_data), 64'(held_d));
               chk("bp_out_sat_stable",  64'(if3.out_sat),  64'(held_s));
            end
            @(posedge clk);
            #1 if3.out_ready = 1'b1;
            @(negedge clk) chk("bp_in_ready_release", 64'(if3.in_ready), 1);
         end
      join
      drain();

      // Reset after two beats of a group: partial sum and group position discarded.
      beat3(16384, 16384, 12345, 1'b0);
      beat3(16384, 16384, 0, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(if3.out_valid), 0);
      chk("midrst_out_data",  64'(if3.out_data), 0);
      chk("midrst_out_sat",   64'(if3.out_sat), 0);
      @(negedge clk) rst_n = 1'b1;
      exp3("post_reset", 49152, 0);
      beat3(16384, 16384, 0, 1'b0);
      beat3(16384, 16384, 0, 1'b0);
      beat3(16384, 16384, 0, 1'b0);
      drain();
      repeat (5) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
